// File: rtl/ddr3_axi_mem_tester.sv
`default_nettype none
// =============================================================================
// Module   : ddr3_axi_mem_tester
// Brief    : AXI4 master BIST - writes a deterministic pattern, reads it back
//            and checks it. Define MEM_TESTER_LFSR_EN for an LFSR data pattern.
// Revision : 1.0 - initial release
// =============================================================================
module ddr3_axi_mem_tester #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                ID_W       = 4,
    parameter int                BURST_LEN  = 8,
    parameter int                NUM_BURSTS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]       SEED       = 32'hA5A5_0000,
    parameter int                CNT_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic [ADDR_W-1:0]   err_addr_o,
    output logic [DATA_W-1:0]   err_data_o,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [ID_W-1:0]     m_awid,
    output logic [7:0]          m_awlen,
    output logic [1:0]          m_awburst,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    input  logic [ID_W-1:0]     m_bid,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [ID_W-1:0]     m_arid,
    output logic [7:0]          m_arlen,
    output logic [1:0]          m_arburst,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic [ID_W-1:0]     m_rid,
    input  logic                m_rlast
);

    localparam int BEAT_BYTES  = DATA_W / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int REP         = DATA_W / 32;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);

    if (BURST_LEN < 1 || BURST_LEN > 256 || BURST_BYTES > 4096) begin : g_bad_burst
        $error("ddr3_axi_mem_tester: burst must be 1..256 beats and at most 4 KiB");
    end
    if (DATA_W != 32 && DATA_W != 64 && DATA_W != 128) begin : g_bad_width
        $error("ddr3_axi_mem_tester: DATA_W must be 32, 64 or 128");
    end
    if (NUM_BURSTS < 1) begin : g_bad_count
        $error("ddr3_axi_mem_tester: NUM_BURSTS must be at least 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t             state;
    logic [BURST_W-1:0] burst;
    logic [BEAT_W-1:0]  beat;
    logic [1:0]         mode_r;

    logic [ADDR_W-1:0]  burst_addr;
    logic [ADDR_W-1:0]  beat_addr;
    logic [ID_W-1:0]    cur_id;
    logic [31:0]        pat_word;
    logic [DATA_W-1:0]  exp_data;
    logic               w_hs, b_hs, r_hs, last_burst, is_last_beat;
    logic               b_err, r_err, beat_err;

    assign burst_addr   = BASE_ADDR + ADDR_W'(burst) * ADDR_W'(BURST_BYTES);
    assign beat_addr    = burst_addr + ADDR_W'(beat) * ADDR_W'(BEAT_BYTES);
    assign cur_id       = ID_W'(burst);
    assign exp_data     = {REP{pat_word}};
    assign w_hs         = m_wvalid && m_wready;
    assign b_hs         = m_bvalid && m_bready;
    assign r_hs         = m_rvalid && m_rready;
    assign last_burst   = (burst == LAST_BURST);
    assign is_last_beat = (beat == LAST_BEAT);

`ifdef MEM_TESTER_LFSR_EN
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    logic [31:0] lfsr;
    logic        lfsr_load;

    // Reload at the start of each phase so read-back regenerates the written sequence
    assign lfsr_load = (start_i && (state == S_IDLE || state == S_DONE)) ||
                       (b_hs && last_burst && mode_r != 2'b01);
    assign pat_word  = lfsr;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lfsr <= SEED;
        end else if (lfsr_load) begin
            lfsr <= SEED;
        end else if (w_hs || r_hs) begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
        end
    end
`else
    assign pat_word = 32'(beat_addr) ^ SEED;
`endif

    assign b_err    = (m_bresp != 2'b00) || (m_bid != cur_id);
    assign r_err    = (m_rresp != 2'b00) || (m_rdata != exp_data) ||
                      (m_rlast != is_last_beat) || (m_rid != cur_id);
    assign beat_err = (b_hs && b_err) || (r_hs && r_err);

    assign m_awaddr  = burst_addr;
    assign m_awid    = cur_id;
    assign m_awlen   = 8'(BURST_LEN - 1);
    assign m_awburst = 2'b01;
    assign m_araddr  = burst_addr;
    assign m_arid    = cur_id;
    assign m_arlen   = 8'(BURST_LEN - 1);
    assign m_arburst = 2'b01;
    assign m_wdata   = exp_data;
    assign m_wstrb   = '1;
    assign m_wlast   = m_wvalid && is_last_beat;
    assign pass_o    = done_o && (err_cnt_o == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            burst      <= '0;
            beat       <= '0;
            mode_r     <= 2'b00;
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_cnt_o  <= '0;
            err_addr_o <= '0;
            err_data_o <= '0;
        end else begin
            // A zero count means no error captured yet in this run
            if (beat_err) begin
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                if (err_cnt_o == '0) begin
                    err_addr_o <= beat_addr;
                    err_data_o <= r_hs ? m_rdata : '0;
                end
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        err_cnt_o  <= '0;
                        err_addr_o <= '0;
                        err_data_o <= '0;
                        mode_r     <= mode_i;
                        burst      <= '0;
                        beat       <= '0;
                        if (mode_i == 2'b10) begin
                            state     <= S_AR;
                            m_arvalid <= 1'b1;
                        end else begin
                            state     <= S_AW;
                            m_awvalid <= 1'b1;
                        end
                    end
                end
                S_AW: begin
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                        m_wvalid  <= 1'b1;
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        if (is_last_beat) begin
                            beat     <= '0;
                            m_wvalid <= 1'b0;
                            m_bready <= 1'b1;
                            state    <= S_B;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_B: begin
                    if (b_hs) begin
                        m_bready <= 1'b0;
                        if (last_burst) begin
                            burst <= '0;
                            if (mode_r == 2'b01) begin
                                state  <= S_DONE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end else begin
                                state     <= S_AR;
                                m_arvalid <= 1'b1;
                            end
                        end else begin
                            burst     <= burst + 1'b1;
                            state     <= S_AW;
                            m_awvalid <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (r_hs) begin
                        if (is_last_beat) begin
                            beat     <= '0;
                            m_rready <= 1'b0;
                            if (last_burst) begin
                                burst  <= '0;
                                state  <= S_DONE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end else begin
                                burst     <= burst + 1'b1;
                                state     <= S_AR;
                                m_arvalid <= 1'b1;
                            end
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_axi_mem_tester.sv
`default_nettype none
// =============================================================================
// Module   : tb_ddr3_axi_mem_tester
// Brief    : Table-driven bench with a reactive AXI slave and expectation queues.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ddr3_axi_mem_tester;

    localparam int          DATA_W     = 32;
    localparam int          ADDR_W     = 32;
    localparam int          ID_W       = 4;
    localparam int          BURST_LEN  = 8;
    localparam int          NUM_BURSTS = 4;
    localparam int          CNT_W      = 4;
    localparam logic [31:0] BASE       = 32'h0;
    localparam logic [31:0] SEED       = 32'hA5A5_0000;
    localparam logic [31:0] POLY       = 32'h8020_0003;

    typedef struct packed {
        logic [31:0]     addr;
        logic [ID_W-1:0] id;
    } addr_t;

    typedef struct {
        logic [1:0]  mode;
        bit          stall;
        int          kind;
        int          exp_aw;
        int          exp_w;
        int          exp_ar;
        int          exp_r;
        int          exp_cnt;
        logic [31:0] exp_eaddr;
        logic [31:0] exp_edata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic busy, done, pass;
    logic [CNT_W-1:0] err_cnt;
    logic [31:0] err_addr, err_data;
    logic awvalid, awready = 1'b0;
    logic [31:0] awaddr;
    logic [ID_W-1:0] awid;
    logic [7:0] awlen;
    logic [1:0] awburst;
    logic wvalid, wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic wlast;
    logic bvalid = 1'b0, bready;
    logic [1:0] bresp = 2'b00;
    logic [ID_W-1:0] bid = '0;
    logic arvalid, arready = 1'b0;
    logic [31:0] araddr;
    logic [ID_W-1:0] arid;
    logic [7:0] arlen;
    logic [1:0] arburst;
    logic rvalid = 1'b0, rready;
    logic [31:0] rdata = '0;
    logic [1:0] rresp = 2'b00;
    logic [ID_W-1:0] rid = '0;
    logic rlast = 1'b0;

    ddr3_axi_mem_tester #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .BURST_LEN(BURST_LEN),
        .NUM_BURSTS(NUM_BURSTS), .BASE_ADDR(BASE), .SEED(SEED), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
        .err_addr_o(err_addr), .err_data_o(err_data),
        .m_awvalid(awvalid), .m_awready(awready), .m_awaddr(awaddr), .m_awid(awid),
        .m_awlen(awlen), .m_awburst(awburst),
        .m_wvalid(wvalid), .m_wready(wready), .m_wdata(wdata), .m_wstrb(wstrb), .m_wlast(wlast),
        .m_bvalid(bvalid), .m_bready(bready), .m_bresp(bresp), .m_bid(bid),
        .m_arvalid(arvalid), .m_arready(arready), .m_araddr(araddr), .m_arid(arid),
        .m_arlen(arlen), .m_arburst(arburst),
        .m_rvalid(rvalid), .m_rready(rready), .m_rdata(rdata), .m_rresp(rresp),
        .m_rid(rid), .m_rlast(rlast)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int n, input logic [31:0] addr);
        logic [31:0] l;
`ifdef MEM_TESTER_LFSR_EN
        l = SEED;
        for (int i = 0; i < n; i++) l = (l >> 1) ^ (l[0] ? POLY : 32'h0);
`else
        l = addr ^ SEED;
`endif
        return l;
    endfunction

    // Scoreboard queues (filled at start) and slave state
    addr_t       exp_aw_q[$], exp_ar_q[$], s_aw_q[$], s_ar_q[$];
    logic [31:0] exp_w_q[$];
    logic [ID_W-1:0] s_b_q[$];
    logic [31:0] mem [0:63];
    int cnt_aw, cnt_w, cnt_b, cnt_ar, cnt_r, w_beat, r_beat, kind;
    bit stall_en, b_fire, r_fire, aw_hold, w_hold, ar_hold;
    logic [63:0] hold_aw, hold_w, hold_ar;

    function automatic bit roll();
        return !stall_en || ($urandom_range(0, 1) == 0);
    endfunction

    // Slave: decides at negedge; a handshake committed here happens at the next posedge
    always @(negedge clk) begin
        addr_t a;
        logic [31:0] ba, wexp;
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; arready = 1'b0;
            bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            s_aw_q.delete(); s_ar_q.delete(); s_b_q.delete();
            w_beat = 0; r_beat = 0; b_fire = 0; r_fire = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0;
        end else begin
            if (aw_hold) check("aw_stable", {awvalid, awaddr, awid}, hold_aw);
            awready = roll();
            if (awvalid && awready) begin
                cnt_aw++;
                check("aw_len", awlen, 8'd7);
                check("aw_burst", awburst, 2'b01);
                check("aw_expected", exp_aw_q.size() > 0, 1);
                if (exp_aw_q.size() > 0) begin
                    a = exp_aw_q.pop_front();
                    check("aw_addr", awaddr, a.addr);
                    check("aw_id", awid, a.id);
                end
                s_aw_q.push_back('{awaddr, awid});
            end
            aw_hold = awvalid && !awready;
            hold_aw = {awvalid, awaddr, awid};

            if (w_hold) check("w_stable", {wvalid, wlast, wdata}, hold_w);
            wready = roll();
            if (wvalid && wready) begin
                cnt_w++;
                check("w_strb", wstrb, 4'hF);
                check("w_last", wlast, w_beat == 7);
                check("w_expected", exp_w_q.size() > 0, 1);
                if (exp_w_q.size() > 0) begin
                    wexp = exp_w_q.pop_front();
                    check("w_data", wdata, wexp);
                end
                if (s_aw_q.size() > 0) begin
                    ba = s_aw_q[0].addr + 32'(w_beat * 4);
                    mem[ba[7:2]] = wdata;
                    if (w_beat == 7) begin
                        s_b_q.push_back(s_aw_q[0].id);
                        void'(s_aw_q.pop_front());
                    end
                end
                w_beat = (w_beat == 7) ? 0 : w_beat + 1;
            end
            w_hold = wvalid && !wready;
            hold_w = {wvalid, wlast, wdata};

            if (b_fire) begin
                bvalid = 1'b0;
                cnt_b++;
            end
            if (!bvalid && s_b_q.size() > 0) begin
                bid = s_b_q.pop_front();
                bresp = 2'b00;
                bvalid = 1'b1;
            end
            b_fire = bvalid && bready;

            if (ar_hold) check("ar_stable", {arvalid, araddr, arid}, hold_ar);
            arready = roll();
            if (arvalid && arready) begin
                cnt_ar++;
                check("ar_len", arlen, 8'd7);
                check("ar_burst", arburst, 2'b01);
                check("ar_expected", exp_ar_q.size() > 0, 1);
                if (exp_ar_q.size() > 0) begin
                    a = exp_ar_q.pop_front();
                    check("ar_addr", araddr, a.addr);
                    check("ar_id", arid, a.id);
                end
                s_ar_q.push_back('{araddr, arid});
            end
            ar_hold = arvalid && !arready;
            hold_ar = {arvalid, araddr, arid};

            if (r_fire) begin
                rvalid = 1'b0;
                cnt_r++;
                if (r_beat == 7) begin
                    r_beat = 0;
                    void'(s_ar_q.pop_front());
                end else begin
                    r_beat++;
                end
            end
            if (!rvalid && s_ar_q.size() > 0 && roll()) begin
                ba = s_ar_q[0].addr + 32'(r_beat * 4);
                rdata = mem[ba[7:2]];
                rid = s_ar_q[0].id;
                rresp = 2'b00;
                rlast = (r_beat == 7);
                if (kind == 1 && ba == 32'h4C) rdata[0] = ~rdata[0];
                if (kind == 2) rdata = 32'h0;
                if (kind == 3 && s_ar_q[0].addr == 32'h20) rid = rid ^ 4'd1;
                rvalid = 1'b1;
            end
            r_fire = rvalid && rready;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_expect(input logic [1:0] m);
        logic [31:0] ba;
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
        for (int b = 0; b < NUM_BURSTS; b++) begin
            ba = BASE + 32'(b * 32);
            if (m != 2'b10) begin
                exp_aw_q.push_back('{ba, ID_W'(b)});
                for (int k = 0; k < BURST_LEN; k++)
                    exp_w_q.push_back(model_word(b * 8 + k, ba + 32'(k * 4)));
            end
            if (m != 2'b01) exp_ar_q.push_back('{ba, ID_W'(b)});
        end
        cnt_aw = 0; cnt_w = 0; cnt_b = 0; cnt_ar = 0; cnt_r = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        load_expect(v.mode);
        stall_en = v.stall;
        kind = v.kind;
        start = 1'b1;
        mode = v.mode;
        tick();
        start = 1'b0;
        check("busy_on_start", busy, 1);
        check("done_cleared", done, 0);
        cyc = 0;
        while (!done && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("done_reached", done, 1);
        check("busy_at_done", busy, 0);
        check("pass", pass, v.exp_cnt == 0);
        check("err_cnt", err_cnt, v.exp_cnt);
        check("err_addr", err_addr, v.exp_eaddr);
        check("err_data", err_data, v.exp_edata);
        check("aw_count", cnt_aw, v.exp_aw);
        check("w_count", cnt_w, v.exp_w);
        check("b_count", cnt_b, v.exp_aw);
        check("ar_count", cnt_ar, v.exp_ar);
        check("r_count", cnt_r, v.exp_r);
        check("queues_left", exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
        tick();
        tick();
        check("done_level", {done, arvalid, awvalid}, 3'b100);
    endtask

    vec_t vecs[8];

    initial begin
        int cyc;
        vecs[0] = '{2'b00, 1'b0, 0, 4, 32, 4, 32, 0, 32'h0, 32'h0};
        vecs[1] = '{2'b01, 1'b1, 0, 4, 32, 0, 0, 0, 32'h0, 32'h0};
        vecs[2] = '{2'b10, 1'b1, 0, 0, 0, 4, 32, 0, 32'h0, 32'h0};
        vecs[3] = '{2'b00, 1'b0, 1, 4, 32, 4, 32, 1, 32'h4C, model_word(19, 32'h4C) ^ 32'h1};
        vecs[4] = '{2'b11, 1'b1, 0, 4, 32, 4, 32, 0, 32'h0, 32'h0};
        vecs[5] = '{2'b10, 1'b0, 2, 0, 0, 4, 32, 15, 32'h0, 32'h0};
        vecs[6] = '{2'b00, 1'b1, 3, 4, 32, 4, 32, 8, 32'h20, model_word(8, 32'h20)};
        vecs[7] = '{2'b10, 1'b0, 0, 0, 0, 4, 32, 0, 32'h0, 32'h0};

        repeat (3) tick();
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check("rst_status", {busy, done, pass}, 3'b0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_err_data", err_data, 0);
        rst_n = 1'b1;
        tick();

        // Abandon a run in the middle of the first write burst
        load_expect(2'b00);
        stall_en = 1'b0;
        kind = 0;
        start = 1'b1;
        mode = 2'b00;
        tick();
        start = 1'b0;
        cyc = 0;
        while (cnt_w < 6 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("mid_w_reached", cnt_w, 6);
        check("mid_wvalid", {wvalid, busy}, 2'b11);
        rst_n = 1'b0;
        tick();
        check("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check("midrst_busy", {busy, done}, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
